// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer and the instruction
// register it loads.
package rv_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A1,
    S_L1,
    S_A2,
    S_L2,
    S_VALID
  } state_t;

  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_B1   = 2'b01;
  localparam logic [1:0] FETCH_B2   = 2'b10;

  localparam int OPC_W        = 3;
  localparam int AD1_W        = 5;
  localparam int AD2_W        = 8;
  localparam int TWO_BYTE_BIT = 2;

  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [AD1_W-1:0] ad1;
  } b1_t;

  // Opcode sits above ad1 in byte 1; its top bit marks a two-byte instruction.
  function automatic logic is_two_byte(input logic [7:0] b1);
    return b1[AD1_W+TWO_BYTE_BIT];
  endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// ROM read port, instr_reg load port and execute handshake of the fetch sequencer.
interface fetch_seq_if #(parameter int PC_W = 8);
  logic            rom_rd;
  logic [PC_W-1:0] rom_addr;
  logic [7:0]      rom_data;
  logic [1:0]      fetch;
  logic [7:0]      data;
  logic            ir_valid;
  logic            ir_ready;

  modport master (
    output rom_rd, rom_addr, fetch, data, ir_valid,
    input  rom_data, ir_ready
  );

  modport slave (
    input  rom_rd, rom_addr, fetch, data, ir_valid,
    output rom_data, ir_ready
  );
endinterface

// File: rtl/fetch_seq_pc_counter.sv
// Program counter: load has priority over increment; increment wraps naturally.
module pc_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: reads one or two bytes from the synchronous ROM,
// loads them into instr_reg and holds ir_valid until execute accepts.
module fetch_seq
  import rv_fetch_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  fetch_seq_if.master     bus
);

  state_t state;
  logic   in_fetch;
  logic   pc_inc;

  assign in_fetch = (state == S_A1) || (state == S_L1) ||
                    (state == S_A2) || (state == S_L2);
  assign pc_inc   = (state == S_L1) || (state == S_L2);

  pc_counter #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  // A branch during a fetch drops the partial instruction and restarts at the new pc.
  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else if (pc_load && in_fetch)
      state <= run ? S_A1 : S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (run) state <= S_A1;
        S_A1:    state <= S_L1;
        S_L1:    state <= is_two_byte(bus.rom_data) ? S_A2 : S_VALID;
        S_A2:    state <= S_L2;
        S_L2:    state <= S_VALID;
        S_VALID: if (bus.ir_ready) state <= run ? S_A1 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_rd   = (state == S_A1) || (state == S_A2);
  assign bus.rom_addr = pc;
  assign bus.fetch    = (state == S_L1) ? FETCH_B1 :
                        (state == S_L2) ? FETCH_B2 : FETCH_NONE;
  assign bus.data     = pc_inc ? bus.rom_data : 8'h00;
  assign bus.ir_valid = (state == S_VALID);
  assign busy         = (state != S_IDLE);

endmodule
